// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, FSM states, flag indices and decode helpers
// Contents: opcode localparams OP_*, state_t FSM encoding, FLAG_Z/FLAG_C/FLAG_V
// bit positions in the {v,c,z} flags word, and per-opcode flag/acc update helpers.
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_SHL = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    // Every op that produces a new accumulator value also refreshes z.
    function automatic logic sets_z(input logic [3:0] op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_LDI, OP_SHL, OP_SHR};
    endfunction

    // Loads leave c alone; logic ops write c=0 through the ALU.
    function automatic logic sets_c(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    endfunction

    function automatic logic sets_v(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational accumulator ALU
// Ports: op (opcode), a (accumulator), b (memory word or immediate) ->
// result, c (carry/borrow/shifted-out bit), v (signed overflow), z (result==0).
// Build macro PROC_SIGNED_EN: enables v and makes SHR arithmetic.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              v,
    output logic              z
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the widened subtraction is the borrow (a < b).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // LDA/LDI pass b straight through; the default covers them.
        result = b;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[M:0];
                c      = sum[DATA_W];
`ifdef PROC_SIGNED_EN
                v      = (a[M] == b[M]) && (sum[M] != a[M]);
`endif
            end
            OP_SUB: begin
                result = diff[M:0];
                c      = diff[DATA_W];
`ifdef PROC_SIGNED_EN
                v      = (a[M] != b[M]) && (diff[M] != a[M]);
`endif
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[M-1:0], 1'b0};
                c      = a[M];
            end
            OP_SHR: begin
`ifdef PROC_SIGNED_EN
                result = {a[M], a[M:1]};
`else
                result = {1'b0, a[M:1]};
`endif
                c      = a[0];
            end
            default: ;
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/proc_core.sv
// rtl/proc_core.sv - multi-cycle accumulator processor core (top)
// Ports: clk, rst (async active-low); run/step execution control; ld_we/ld_addr/
// ld_data data RAM preload; prog_addr/prog_data synchronous program ROM;
// acc, pc, flags {v,c,z}, out_val/out_valid, halted, state (debug).
// Build macro PROC_SIGNED_EN: signed overflow flag, arithmetic SHR, opcode B = JV.
module proc_core
    import proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic [PC_W-1:0]     prog_addr,
    input  logic [ADDR_W+3:0]   prog_data,
    output logic [DATA_W-1:0]   acc,
    output logic [PC_W-1:0]     pc,
    output logic [2:0]          flags,
    output logic [DATA_W-1:0]   out_val,
    output logic                out_valid,
    output logic                halted,
    output logic [2:0]          state
);

`ifdef PROC_SIGNED_EN
    localparam int JC_FLAG = FLAG_V;
`else
    localparam int JC_FLAG = FLAG_C;
`endif

    state_t state_q, state_d;

    logic [ADDR_W+3:0]  ir;
    logic [3:0]         op;
    logic [ADDR_W-1:0]  operand;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_c, alu_v, alu_z;
    logic [PC_W-1:0]    target;

    logic [DATA_W-1:0]  ram [2**ADDR_W];

    assign op      = ir[ADDR_W+3:ADDR_W];
    assign operand = ir[ADDR_W-1:0];
    assign target  = PC_W'(operand);
    assign alu_b   = (op == OP_LDI) ? DATA_W'(operand) : ram[operand];

    // The ROM registers its address at the end of FETCH, so presenting pc
    // directly gives the word in DECODE, where ir captures it.
    assign prog_addr = pc;
    assign state     = state_q;

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (acc),
        .b      (alu_b),
        .result (alu_result),
        .c      (alu_c),
        .v      (alu_v),
        .z      (alu_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run || step) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op == OP_HLT) state_d = S_HALT;
                else if (run)     state_d = S_FETCH;
                else              state_d = S_IDLE;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir        <= '0;
            pc        <= '0;
            acc       <= '0;
            flags     <= '0;
            out_val   <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                S_DECODE: begin
                    ir <= prog_data;
                    pc <= pc + PC_W'(1);
                end
                S_EXEC: begin
                    if (sets_z(op)) begin
                        acc           <= alu_result;
                        flags[FLAG_Z] <= alu_z;
                    end
                    if (sets_c(op)) flags[FLAG_C] <= alu_c;
                    if (sets_v(op)) flags[FLAG_V] <= alu_v;
                    case (op)
                        OP_JMP: pc <= target;
                        OP_JZ:  if (flags[FLAG_Z])  pc <= target;
                        OP_JC:  if (flags[JC_FLAG]) pc <= target;
                        OP_OUT: begin
                            out_val   <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_HLT: halted <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // No reset on the RAM: contents survive rst. During reset the FSM sits in
    // IDLE, so an STA that has not reached its edge never writes.
    always_ff @(posedge clk) begin
        if (state_q == S_EXEC && op == OP_STA)
            ram[operand] <= acc;
        else if (ld_we && (state_q == S_IDLE || state_q == S_HALT))
            ram[ld_addr] <= ld_data;
    end

endmodule

// File: tb/tb_proc_core.sv
// tb/tb_proc_core.sv - self-checking bench for proc_core with an ISA-level model
module tb_proc_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       ld_we = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [4:0] prog_addr;
    logic [7:0] prog_data = '0;
    logic [7:0] acc;
    logic [4:0] pc;
    logic [2:0] flags;
    logic [7:0] out_val;
    logic       out_valid;
    logic       halted;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [32];
    int         mram [16];
    int         out_q [$];
    int         exp_out [$];
    int         exp_acc, exp_flags, exp_pc;

    proc_core #(.DATA_W(8), .ADDR_W(4), .PC_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .acc       (acc),
        .pc        (pc),
        .flags     (flags),
        .out_val   (out_val),
        .out_valid (out_valid),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    always @(negedge clk) if (rst && out_valid === 1'b1) out_q.push_back(int'(out_val));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int opd);
        ins = {op[3:0], opd[3:0]};
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'hF0;
    endtask

    task automatic do_reset();
        run = 1'b0; step = 1'b0; ld_we = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        out_q.delete();
    endtask

    task automatic load(input int a, input int d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a[3:0]; ld_data = d[7:0];
        @(negedge clk) ld_we = 1'b0;
        mram[a] = d;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        @(negedge clk) run = 1'b1;
        while (halted !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk({tag, "_halted"}, 32'(halted), 1);
    endtask

    // Instruction-level interpreter: each ROM word is one architectural step.
    task automatic model_run();
        int p, a, m, o, op, s;
        bit zf, cf, vf, done;
        p = 0; a = 0; zf = 0; cf = 0; vf = 0; done = 0;
        exp_out.delete();
        for (int k = 0; k < 200 && !done; k++) begin
            op = int'(rom[p][7:4]);
            o  = int'(rom[p][3:0]);
            p  = (p + 1) % 32;
            m  = mram[o];
            case (op)
                1: begin a = m; zf = (a == 0); end
                2: mram[o] = a;
                3: begin
                    s = a + m; cf = (s > 255);
`ifdef PROC_SIGNED_EN
                    vf = (((a ^ m) & 128) == 0) && (((a ^ s) & 128) != 0);
`endif
                    a = s & 255; zf = (a == 0);
                end
                4: begin
                    s = a - m; cf = (a < m);
`ifdef PROC_SIGNED_EN
                    vf = (((a ^ m) & 128) != 0) && (((a ^ s) & 128) != 0);
`endif
                    a = s & 255; zf = (a == 0);
                end
                5: begin a = a & m; cf = 0; zf = (a == 0); end
                6: begin a = a | m; cf = 0; zf = (a == 0); end
                7: begin a = a ^ m; cf = 0; zf = (a == 0); end
                8: begin a = o; zf = (a == 0); end
                9: p = o;
                10: if (zf) p = o;
`ifdef PROC_SIGNED_EN
                11: if (vf) p = o;
`else
                11: if (cf) p = o;
`endif
                12: begin cf = (a >> 7) & 1; a = (a << 1) & 255; zf = (a == 0); end
                13: begin
                    cf = a & 1;
`ifdef PROC_SIGNED_EN
                    a = (a >> 1) | (a & 128);
`else
                    a = a >> 1;
`endif
                    zf = (a == 0);
                end
                14: exp_out.push_back(a);
                15: done = 1;
                default: ;
            endcase
        end
        exp_acc = a; exp_flags = {29'd0, vf, cf, zf}; exp_pc = p;
    endtask

    initial begin
        int n;
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 13, 14};
        fill_rom();
        for (int i = 0; i < 16; i++) mram[i] = 0;

        // Reset state while rst is held low
        #23;
        chk("rst_acc", 32'(acc), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_prog_addr", 32'(prog_addr), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_state", 32'(state), 0);

        // LDA 0; ADD 1; OUT; HLT
        do_reset();
        load(0, 8'h25); load(1, 8'h17);
        fill_rom();
        rom[0] = ins(1, 0); rom[1] = ins(3, 1); rom[2] = ins(14, 0); rom[3] = ins(15, 0);
        run_to_halt("add");
        chk("add_out_cnt", 32'(out_q.size()), 1);
        if (out_q.size() > 0) chk("add_out_val", 32'(out_q[0]), 32'h3C);
        chk("add_out_val_hold", 32'(out_val), 32'h3C);
        chk("add_pc", 32'(pc), 4);
        chk("add_flags", 32'(flags), 0);
        chk("add_state", 32'(state), 4);

        // Carry then JC 6 taken
        do_reset();
        load(0, 8'hF0); load(1, 8'h20);
        fill_rom();
        rom[0] = ins(1, 0); rom[1] = ins(3, 1); rom[2] = ins(11, 6);
        rom[3] = ins(8, 1); rom[4] = ins(14, 0); rom[6] = ins(15, 0);
        run_to_halt("jc");
        chk("jc_acc", 32'(acc), 32'h10);
        chk("jc_flags", 32'(flags), 3'b010);
        chk("jc_pc", 32'(pc), 7);
        chk("jc_no_out", 32'(out_q.size()), 0);

        // Equal SUB sets z, JZ taken
        do_reset();
        load(2, 8'h33);
        fill_rom();
        rom[0] = ins(1, 2); rom[1] = ins(4, 2); rom[2] = ins(10, 4); rom[3] = ins(8, 9);
        run_to_halt("subeq");
        chk("subeq_acc", 32'(acc), 0);
        chk("subeq_flags", 32'(flags), 3'b001);
        chk("subeq_pc", 32'(pc), 5);

        // Unsigned borrow
        do_reset();
        load(3, 8'h10); load(4, 8'h20);
        fill_rom();
        rom[0] = ins(1, 3); rom[1] = ins(4, 4);
        run_to_halt("borrow");
        chk("borrow_acc", 32'(acc), 32'hF0);
        chk("borrow_flags", 32'(flags), 3'b010);

        // Single-step over NOP, NOP, LDI 7
        do_reset();
        fill_rom();
        rom[0] = ins(0, 0); rom[1] = ins(0, 0); rom[2] = ins(8, 7);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk) step = 1'b1;
            @(negedge clk) step = 1'b0;
            chk($sformatf("step%0d_fetch", k), 32'(state), 1);
            repeat (3) @(negedge clk);
            chk($sformatf("step%0d_idle", k), 32'(state), 0);
            chk($sformatf("step%0d_pc", k), 32'(pc), k);
            chk($sformatf("step%0d_acc", k), 32'(acc), (k == 3) ? 7 : 0);
        end

        // Free-run NOPs: pc wraps; ld_we while running is ignored
        do_reset();
        load(5, 8'hAA);
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        @(negedge clk) run = 1'b1;
        n = 0;
        while (pc !== 5'd31 && n < 400) begin @(negedge clk); n++; end
        chk("wrap_reach31", 32'(pc), 31);
        n = 0;
        while (pc === 5'd31 && n < 20) begin @(negedge clk); n++; end
        chk("wrap_to0", 32'(pc), 0);
        ld_we = 1'b1; ld_addr = 4'd5; ld_data = 8'h55;
        @(negedge clk) ld_we = 1'b0;
        run = 1'b0;
        n = 0;
        while (state !== 3'd0 && n < 6) begin @(negedge clk); n++; end
        chk("runstop_idle", 32'(state), 0);
        do_reset();
        fill_rom();
        rom[0] = ins(1, 5);
        run_to_halt("ldrun");
        chk("ldrun_ram_kept", 32'(acc), 32'hAA);

        // Reset during EXEC of STA
        do_reset();
        load(6, 8'h12);
        fill_rom();
        rom[0] = ins(8, 9); rom[1] = ins(2, 6);
        @(negedge clk) run = 1'b1;
        n = 0;
        while (!(state === 3'd3 && pc === 5'd2) && n < 50) begin @(negedge clk); n++; end
        chk("sta_reach_exec", 32'(acc), 9);
        rst = 1'b0;
        #1;
        chk("starst_acc", 32'(acc), 0);
        chk("starst_pc", 32'(pc), 0);
        chk("starst_prog_addr", 32'(prog_addr), 0);
        chk("starst_flags", 32'(flags), 0);
        chk("starst_out_val", 32'(out_val), 0);
        chk("starst_out_valid", 32'(out_valid), 0);
        chk("starst_halted", 32'(halted), 0);
        chk("starst_state", 32'(state), 0);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        fill_rom();
        rom[0] = ins(1, 6);
        run_to_halt("starst");
        chk("starst_ram_intact", 32'(acc), 32'h12);

        // Random straight-line programs against the model
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int i = 0; i < 16; i++) load(i, int'($urandom_range(255)));
            fill_rom();
            for (int i = 0; i < 12; i++)
                rom[i] = ins(ops[$urandom_range(11)], int'($urandom_range(15)));
            model_run();
            run_to_halt($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d_acc", t), 32'(acc), 32'(exp_acc));
            chk($sformatf("rnd%0d_flags", t), 32'(flags), 32'(exp_flags));
            chk($sformatf("rnd%0d_pc", t), 32'(pc), 32'(exp_pc));
            chk($sformatf("rnd%0d_out_cnt", t), 32'(out_q.size()), 32'(exp_out.size()));
            for (int i = 0; i < exp_out.size() && i < out_q.size(); i++)
                chk($sformatf("rnd%0d_out%0d", t, i), 32'(out_q[i]), 32'(exp_out[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
